// File: rtl/mips_mc_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: a Moore machine that walks each
// instruction through fetch/decode/execute/memory/writeback and drives the datapath selects.
module mips_mc_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;

  logic pcwrite_s;
  logic branch_s;
  logic memwrite_s;
  logic irwrite_s;
  logic regwrite_s;
  logic illegal_s;
  logic done_s;
  logic wr_ok_s;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stall holds, unreachable codes recover to FETCH
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEXEC;
            OP_J:         state_d = S_JUMP;
            default:      state_d = S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (opcode == OP_SW) begin
            state_d = S_MEMWR;
          end else if (opcode == OP_LW) begin
            state_d = S_MEMRD;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEMRD:    state_d = S_MEMWB;
        S_EXECUTE:  state_d = S_ALUWB;
        S_ADDIEXEC: state_d = S_ADDIWB;
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  // Moore output decode of the current state
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    done_s     = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb   = 2'b01;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_s = 1'b0;
          default: illegal_s = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
        done_s     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
        done_s     = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_s = 1'b1;
        done_s   = 1'b1;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
        done_s    = 1'b1;
      end
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Writes and pulses are suppressed during stall and while reset is held
  assign wr_ok_s    = en & ~rst;
  assign pcen       = (pcwrite_s | (branch_s & zero)) & wr_ok_s;
  assign memwrite   = memwrite_s & wr_ok_s;
  assign irwrite    = irwrite_s & wr_ok_s;
  assign regwrite   = regwrite_s & wr_ok_s;
  assign illegal    = illegal_s & wr_ok_s;
  assign instr_done = done_s & wr_ok_s;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed self-checking bench for mips_mc_ctrl: one task per instruction class/scenario.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [5:0] opcode;
  logic       zero;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       illegal, instr_done;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  mips_mc_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal),
    .instr_done(instr_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; opcode = 6'h00; zero = 1'b0;
    tick(); tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_o); end
    checks++; if (irwrite !== 1'b0 || pcen !== 1'b0) begin errors++; $display("FAIL rst_gate irwrite=%b pcen=%b want 0 0", irwrite, pcen); end
    rst = 1'b0; #1;
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL rel_state got %0d want 0", state_o); end
    checks++; if (irwrite !== 1'b1 || pcen !== 1'b1) begin errors++; $display("FAIL rel_fetch irwrite=%b pcen=%b want 1 1", irwrite, pcen); end
    checks++; if (alusrcb !== 2'b01) begin errors++; $display("FAIL rel_alusrcb got %b want 01", alusrcb); end
    checks++; if (regwrite !== 1'b0 || memwrite !== 1'b0) begin errors++; $display("FAIL rel_wr regwrite=%b memwrite=%b want 0 0", regwrite, memwrite); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode = 6'h23;
    for (int i = 0; i < 5; i++) begin
      checks++; if (state_o !== exp_st[i]) begin errors++; $display("FAIL lw_state step %0d got %0d want %0d", i, state_o, exp_st[i]); end
      checks++; if (instr_done !== (i == 4)) begin errors++; $display("FAIL lw_done step %0d got %b", i, instr_done); end
      if (i == 1) begin
        checks++; if (alusrcb !== 2'b11) begin errors++; $display("FAIL dec_alusrcb got %b want 11", alusrcb); end
      end
      if (i == 2) begin
        checks++; if (alusrca !== 1'b1 || alusrcb !== 2'b10) begin errors++; $display("FAIL lw_memadr a=%b b=%b want 1 10", alusrca, alusrcb); end
      end
      if (i == 3) begin
        checks++; if (iord !== 1'b1 || regwrite !== 1'b0) begin errors++; $display("FAIL lw_memrd iord=%b regwrite=%b want 1 0", iord, regwrite); end
      end
      if (i == 4) begin
        checks++; if (regwrite !== 1'b1 || memtoreg !== 1'b1) begin errors++; $display("FAIL lw_memwb regwrite=%b memtoreg=%b want 1 1", regwrite, memtoreg); end
      end
      tick();
    end
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL lw_return got %0d want 0", state_o); end
  endtask

  task automatic test_beq(input logic z);
    opcode = 6'h04; zero = z;
    tick(); tick();
    checks++; if (state_o !== 4'd8) begin errors++; $display("FAIL beq_state got %0d want 8", state_o); end
    checks++; if (pcsrc !== 2'b01 || aluop !== 2'b01) begin errors++; $display("FAIL beq_sel pcsrc=%b aluop=%b want 01 01", pcsrc, aluop); end
    checks++; if (pcen !== z) begin errors++; $display("FAIL beq_pcen zero=%b got %b want %b", z, pcen, z); end
    checks++; if (instr_done !== 1'b1) begin errors++; $display("FAIL beq_done got %b want 1", instr_done); end
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL beq_return got %0d want 0", state_o); end
    zero = 1'b0;
  endtask

  task automatic test_jump_illegal();
    opcode = 6'h02;
    tick(); tick();
    checks++; if (state_o !== 4'd11 || pcsrc !== 2'b10 || pcen !== 1'b1) begin errors++; $display("FAIL jump st=%0d pcsrc=%b pcen=%b want 11 10 1", state_o, pcsrc, pcen); end
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL jump_return got %0d want 0", state_o); end
    opcode = 6'h3F;
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_fetch got %b want 0", illegal); end
    tick();
    checks++; if (state_o !== 4'd1 || illegal !== 1'b1) begin errors++; $display("FAIL ill_decode st=%0d illegal=%b want 1 1", state_o, illegal); end
    tick();
    checks++; if (state_o !== 4'd0 || illegal !== 1'b0) begin errors++; $display("FAIL ill_next st=%0d illegal=%b want 0 0", state_o, illegal); end
  endtask

  task automatic test_sw_stall();
    opcode = 6'h2B;
    tick(); tick(); tick();
    checks++; if (state_o !== 4'd5) begin errors++; $display("FAIL sw_state got %0d want 5", state_o); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (memwrite !== 1'b0 || state_o !== 4'd5 || iord !== 1'b1) begin errors++; $display("FAIL sw_stall cyc %0d memwrite=%b st=%0d iord=%b want 0 5 1", i, memwrite, state_o, iord); end
      checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL sw_stall_done got %b want 0", instr_done); end
      tick();
    end
    en = 1'b1; #1;
    checks++; if (memwrite !== 1'b1 || instr_done !== 1'b1) begin errors++; $display("FAIL sw_write memwrite=%b done=%b want 1 1", memwrite, instr_done); end
    tick();
    checks++; if (state_o !== 4'd0 || memwrite !== 1'b0) begin errors++; $display("FAIL sw_return st=%0d memwrite=%b want 0 0", state_o, memwrite); end
  endtask

  task automatic test_fetch_stall();
    en = 1'b0; #1;
    checks++; if (irwrite !== 1'b0 || pcen !== 1'b0 || alusrcb !== 2'b01) begin errors++; $display("FAIL fetch_stall irwrite=%b pcen=%b alusrcb=%b want 0 0 01", irwrite, pcen, alusrcb); end
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL fetch_hold got %0d want 0", state_o); end
    en = 1'b1;
  endtask

  task automatic test_rtype_addi();
    opcode = 6'h00;
    tick(); tick();
    checks++; if (state_o !== 4'd6 || aluop !== 2'b10 || alusrca !== 1'b1) begin errors++; $display("FAIL r_exec st=%0d aluop=%b a=%b want 6 10 1", state_o, aluop, alusrca); end
    tick();
    checks++; if (state_o !== 4'd7 || regwrite !== 1'b1 || regdst !== 1'b1) begin errors++; $display("FAIL r_wb st=%0d regwrite=%b regdst=%b want 7 1 1", state_o, regwrite, regdst); end
    tick();
    opcode = 6'h08;
    tick(); tick();
    checks++; if (state_o !== 4'd9 || alusrcb !== 2'b10 || alusrca !== 1'b1) begin errors++; $display("FAIL addi_exec st=%0d b=%b a=%b want 9 10 1", state_o, alusrcb, alusrca); end
    tick();
    checks++; if (state_o !== 4'd10 || regwrite !== 1'b1 || regdst !== 1'b0 || memtoreg !== 1'b0) begin errors++; $display("FAIL addi_wb st=%0d rw=%b rd=%b mtr=%b want 10 1 0 0", state_o, regwrite, regdst, memtoreg); end
    tick();
    checks++; if (state_o !== 4'd0) begin errors++; $display("FAIL addi_return got %0d want 0", state_o); end
  endtask

  task automatic test_rtype_reset();
    opcode = 6'h00;
    tick(); tick();
    checks++; if (state_o !== 4'd6) begin errors++; $display("FAIL rr_exec got %0d want 6", state_o); end
    rst = 1'b1; #1;
    checks++; if (regwrite !== 1'b0 || irwrite !== 1'b0) begin errors++; $display("FAIL rr_hold regwrite=%b irwrite=%b want 0 0", regwrite, irwrite); end
    tick();
    checks++; if (state_o !== 4'd0 || regwrite !== 1'b0) begin errors++; $display("FAIL rr_abort st=%0d regwrite=%b want 0 0", state_o, regwrite); end
    rst = 1'b0; opcode = 6'h3F; #1;
    checks++; if (state_o !== 4'd0 || regwrite !== 1'b0 || irwrite !== 1'b1) begin errors++; $display("FAIL rr_release st=%0d rw=%b ir=%b want 0 0 1", state_o, regwrite, irwrite); end
    tick();
    checks++; if (regwrite !== 1'b0) begin errors++; $display("FAIL rr_after got regwrite=%b want 0", regwrite); end
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump_illegal();
    test_sw_stall();
    test_fetch_stall();
    test_rtype_addi();
    test_rtype_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
